// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug command sequencer: op codes, bus addresses,
// CTRL write-bit / status-bit positions and the sequencer state encoding.
package dbg_pkg;

    typedef enum logic [2:0] {
        OP_HALT    = 3'd0,
        OP_RESUME  = 3'd1,
        OP_STEP    = 3'd2,
        OP_INJECT  = 3'd3,
        OP_RD_STAT = 3'd4,
        OP_RD_INJ  = 3'd5,
        OP_CPU_RST = 3'd6,
        OP_RSVD    = 3'd7
    } dbg_op_e;

    localparam logic [7:0] ADDR_CTRL = 8'h00;
    localparam logic [7:0] ADDR_INJ  = 8'h04;

    localparam int CTRL_STEP      = 4;
    localparam int CTRL_SET_RESET = 16;
    localparam int CTRL_SET_HALT  = 17;
    localparam int CTRL_CLR_RESET = 24;
    localparam int CTRL_CLR_HALT  = 25;

    localparam int ST_RESET_IT   = 0;
    localparam int ST_HALT_IT    = 1;
    localparam int ST_PIP_BUSY   = 2;
    localparam int ST_HALTED_BRK = 3;
    localparam int ST_STEP_IT    = 4;
    localparam int ST_RESET_OUT  = 31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_POLL_GAP,
        S_POLL_ISSUE,
        S_POLL_WAIT,
        S_DONE
    } dbg_state_e;

    function automatic logic [31:0] ctrl_bit(input int pos);
        return 32'd1 << pos;
    endfunction

endpackage

// File: rtl/debug_cmd_seq_if.sv
// CPU debug bus: command channel driven by the sequencer, read data and resetOut from the core.
interface debug_cmd_seq_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] rsp_data;
    logic        reset_out;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data,
        input  cmd_ready, rsp_data, reset_out
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data,
        output cmd_ready, rsp_data, reset_out
    );

endinterface

// File: rtl/dbg_poll_timer.sv
// Inter-poll gap counter plus a saturating poll counter that only exists when
// DBG_CMD_TIMEOUT_EN is defined; otherwise expired is tied low.
module dbg_poll_timer #(
    parameter int unsigned POLL_GAP     = 4,
    parameter int unsigned POLL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic gap_run,
    input  logic tick,
    output logic gap_done,
    output logic expired
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    logic [GW-1:0] gap_cnt;

    // gap_done flags the last idle cycle so the poll read launches right after it
    assign gap_done = gap_run && ((32'(gap_cnt) + 32'd1) >= POLL_GAP);

    always_ff @(posedge clk) begin
        if (reset || start)
            gap_cnt <= '0;
        else if (gap_run)
            gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
    end

`ifdef DBG_CMD_TIMEOUT_EN
    localparam int TW = $clog2(POLL_TIMEOUT + 1);

    logic [TW-1:0] poll_cnt;

    always_ff @(posedge clk) begin
        if (reset || start)
            poll_cnt <= '0;
        else if (tick && (32'(poll_cnt) < POLL_TIMEOUT))
            poll_cnt <= poll_cnt + 1'b1;
    end

    assign expired = tick && ((32'(poll_cnt) + 32'd1) >= POLL_TIMEOUT);
`else
    localparam int unsigned UNUSED_TIMEOUT = POLL_TIMEOUT;
    logic unused_tick;
    assign unused_tick = tick;
    assign expired     = 1'b0;
`endif

endmodule

// File: rtl/debug_cmd_seq.sv
// Debug command sequencer: expands one host request into debug-bus writes/reads and CTRL polling.
// Optional poll timeout is enabled with the DBG_CMD_TIMEOUT_EN macro.
module debug_cmd_seq
    import dbg_pkg::*;
#(
    parameter int unsigned POLL_TIMEOUT = 1024,
    parameter int unsigned POLL_GAP     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  dbg_op_e              req_op,
    input  logic [31:0]          req_data,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    debug_cmd_seq_if.master      dbg
);

    dbg_state_e  state, state_nxt;
    dbg_op_e     op_q, op_nxt;
    logic        second_q, second_nxt;
    logic        cmd_valid_q, cmd_valid_nxt;
    logic        cmd_wr_q, cmd_wr_nxt;
    logic [7:0]  cmd_addr_q, cmd_addr_nxt;
    logic [31:0] cmd_data_q, cmd_data_nxt;
    logic        rsp_valid_q, rsp_valid_nxt;
    logic        rsp_err_q, rsp_err_nxt;
    logic [31:0] rsp_data_q, rsp_data_nxt;

    logic        fire, poll_ok;
    logic [31:0] status;
    logic        timer_start, gap_run, poll_tick, gap_done, expired;
    logic        enter_poll, issue_poll;

    dbg_poll_timer #(
        .POLL_GAP     (POLL_GAP),
        .POLL_TIMEOUT (POLL_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (timer_start),
        .gap_run  (gap_run),
        .tick     (poll_tick),
        .gap_done (gap_done),
        .expired  (expired)
    );

    assign req_ready = (state == S_IDLE) && !reset;
    assign fire      = cmd_valid_q && dbg.cmd_ready;
    assign status    = {dbg.reset_out, dbg.rsp_data[30:0]};

    always_comb begin
        poll_ok = 1'b0;
        case (op_q)
            OP_HALT:   poll_ok = status[ST_HALT_IT];
            OP_STEP:   poll_ok = status[ST_HALT_IT] && !status[ST_PIP_BUSY];
            OP_INJECT: poll_ok = !status[ST_PIP_BUSY];
            default:   poll_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        second_nxt    = second_q;
        cmd_valid_nxt = cmd_valid_q;
        cmd_wr_nxt    = cmd_wr_q;
        cmd_addr_nxt  = cmd_addr_q;
        cmd_data_nxt  = cmd_data_q;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_data_nxt  = rsp_data_q;
        timer_start   = 1'b0;
        gap_run       = 1'b0;
        poll_tick     = 1'b0;
        enter_poll    = 1'b0;
        issue_poll    = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_nxt        = req_op;
                    second_nxt    = 1'b0;
                    state_nxt     = S_ISSUE;
                    cmd_valid_nxt = (req_op != OP_RSVD);
                    cmd_wr_nxt    = !(req_op == OP_RD_STAT || req_op == OP_RD_INJ);
                    cmd_addr_nxt  = (req_op == OP_INJECT || req_op == OP_RD_INJ) ? ADDR_INJ : ADDR_CTRL;
                    case (req_op)
                        OP_HALT:    cmd_data_nxt = ctrl_bit(CTRL_SET_HALT);
                        OP_RESUME:  cmd_data_nxt = ctrl_bit(CTRL_CLR_HALT);
                        OP_STEP:    cmd_data_nxt = ctrl_bit(CTRL_CLR_HALT) | ctrl_bit(CTRL_STEP);
                        OP_INJECT:  cmd_data_nxt = req_data;
                        OP_CPU_RST: cmd_data_nxt = ctrl_bit(CTRL_SET_RESET);
                        default:    cmd_data_nxt = 32'd0;
                    endcase
                end
            end

            S_ISSUE: begin
                // reserved op never touches the bus; it just reports an error
                if (op_q == OP_RSVD) begin
                    state_nxt     = S_DONE;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_data_nxt  = 32'd0;
                end else if (fire) begin
                    cmd_valid_nxt = 1'b0;
                    case (op_q)
                        OP_HALT, OP_STEP, OP_INJECT: begin
                            timer_start = 1'b1;
                            enter_poll  = 1'b1;
                        end
                        OP_RD_STAT, OP_RD_INJ: state_nxt = S_WAIT_RSP;
                        OP_CPU_RST: begin
                            if (!second_q) begin
                                second_nxt    = 1'b1;
                                cmd_valid_nxt = 1'b1;
                                cmd_data_nxt  = ctrl_bit(CTRL_CLR_RESET);
                            end else begin
                                state_nxt     = S_DONE;
                                rsp_valid_nxt = 1'b1;
                                rsp_data_nxt  = 32'd0;
                            end
                        end
                        default: begin
                            state_nxt     = S_DONE;
                            rsp_valid_nxt = 1'b1;
                            rsp_data_nxt  = 32'd0;
                        end
                    endcase
                end
            end

            S_WAIT_RSP: begin
                state_nxt     = S_DONE;
                rsp_valid_nxt = 1'b1;
                rsp_data_nxt  = (op_q == OP_RD_STAT) ? status : dbg.rsp_data;
            end

            S_POLL_GAP: begin
                gap_run = 1'b1;
                if (gap_done)
                    issue_poll = 1'b1;
            end

            S_POLL_ISSUE: begin
                if (fire) begin
                    cmd_valid_nxt = 1'b0;
                    state_nxt     = S_POLL_WAIT;
                end
            end

            S_POLL_WAIT: begin
                poll_tick = 1'b1;
                // success is checked first so a hit on the final allowed poll is not an error
                if (poll_ok || expired) begin
                    state_nxt     = S_DONE;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = !poll_ok;
                    rsp_data_nxt  = status;
                end else begin
                    enter_poll = 1'b1;
                end
            end

            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (enter_poll) begin
            if (POLL_GAP == 0)
                issue_poll = 1'b1;
            else
                state_nxt = S_POLL_GAP;
        end

        if (issue_poll) begin
            state_nxt     = S_POLL_ISSUE;
            cmd_valid_nxt = 1'b1;
            cmd_wr_nxt    = 1'b0;
            cmd_addr_nxt  = ADDR_CTRL;
            cmd_data_nxt  = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= OP_HALT;
            second_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= 8'd0;
            cmd_data_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else begin
            state       <= state_nxt;
            op_q        <= op_nxt;
            second_q    <= second_nxt;
            cmd_valid_q <= cmd_valid_nxt;
            cmd_wr_q    <= cmd_wr_nxt;
            cmd_addr_q  <= cmd_addr_nxt;
            cmd_data_q  <= cmd_data_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_err_q   <= rsp_err_nxt;
            rsp_data_q  <= rsp_data_nxt;
        end
    end

    assign dbg.cmd_valid = cmd_valid_q;
    assign dbg.cmd_wr    = cmd_wr_q;
    assign dbg.cmd_addr  = cmd_addr_q;
    assign dbg.cmd_data  = cmd_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_data      = rsp_data_q;

endmodule

// File: tb/tb_debug_cmd_seq.sv
// Directed bench for debug_cmd_seq: a negedge bus responder logs commands and returns queued status words.
module tb_debug_cmd_seq;
    import dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    dbg_op_e     req_op;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    debug_cmd_seq_if bus();

    debug_cmd_seq #(.POLL_TIMEOUT(8), .POLL_GAP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dbg       (bus)
    );

    initial forever #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_fire, n_wr, n_rd;
    logic        log_wr   [16];
    logic [7:0]  log_addr [16];
    logic [31:0] log_data [16];
    logic [31:0] stat_q   [$];

    // Bus model: a command seen valid&ready at negedge fires on the next posedge;
    // read data is presented from here through the following cycle.
    always @(negedge clk) begin
        if (!reset && bus.cmd_valid && bus.cmd_ready) begin
            if (n_fire < 16) begin
                log_wr[n_fire]   = bus.cmd_wr;
                log_addr[n_fire] = bus.cmd_addr;
                log_data[n_fire] = bus.cmd_data;
            end
            n_fire++;
            if (bus.cmd_wr) n_wr++;
            else begin
                n_rd++;
                if (stat_q.size() > 0) bus.rsp_data = stat_q.pop_front();
                else bus.rsp_data = 32'd0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        n_fire = 0;
        n_wr   = 0;
        n_rd   = 0;
        stat_q.delete();
    endtask

    task automatic send(input dbg_op_e op, input logic [31:0] d);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int max_cyc);
        int k = 0;
        while (rsp_valid !== 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
        check(tag, {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic check_rsp_gone(input string tag);
        tick();
        check({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_op        = OP_HALT;
        req_data      = 32'd0;
        bus.cmd_ready = 1'b1;
        bus.rsp_data  = 32'd0;
        bus.reset_out = 1'b0;
        clear_log();

        // reset state
        tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("rst_cmd_wr", {31'd0, bus.cmd_wr}, 32'd0);
        check("rst_cmd_addr", {24'd0, bus.cmd_addr}, 32'd0);
        check("rst_cmd_data", bus.cmd_data, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // HALT: statuses 0,0,0x2
        clear_log();
        stat_q = '{32'h0, 32'h0, 32'h2};
        send(OP_HALT, 32'h0);
        check("halt_busy_ready", {31'd0, req_ready}, 32'd0);
        wait_rsp("halt_rsp", 100);
        check("halt_data", rsp_data, 32'h2);
        check("halt_err", {31'd0, rsp_err}, 32'd0);
        check("halt_nwr", n_wr, 1);
        check("halt_nrd", n_rd, 3);
        check("halt_wdata", log_data[0], 32'h0002_0000);
        check("halt_waddr", {24'd0, log_addr[0]}, 32'h0);
        check("halt_rd_addr", {24'd0, log_addr[1]}, 32'h0);
        check_rsp_gone("halt");

        // INJECT with ready low for 5 cycles: command must hold steady
        clear_log();
        stat_q = '{32'h4, 32'h2};
        bus.cmd_ready = 1'b0;
        send(OP_INJECT, 32'h0000_0013);
        for (int i = 0; i < 5; i++) begin
            check("inj_hold_valid", {31'd0, bus.cmd_valid}, 32'd1);
            check("inj_hold_wr", {31'd0, bus.cmd_wr}, 32'd1);
            check("inj_hold_addr", {24'd0, bus.cmd_addr}, 32'h04);
            check("inj_hold_data", bus.cmd_data, 32'h0000_0013);
            tick();
        end
        check("inj_no_fire", n_fire, 0);
        bus.cmd_ready = 1'b1;
        wait_rsp("inj_rsp", 100);
        check("inj_nwr", n_wr, 1);
        check("inj_nrd", n_rd, 2);
        check("inj_waddr", {24'd0, log_addr[0]}, 32'h04);
        check("inj_data", rsp_data, 32'h2);
        check("inj_err", {31'd0, rsp_err}, 32'd0);
        check_rsp_gone("inj");

        // RD_INJ returns raw read data
        clear_log();
        stat_q = '{32'hDEAD_BEEF};
        send(OP_RD_INJ, 32'h0);
        wait_rsp("rdinj_rsp", 20);
        check("rdinj_data", rsp_data, 32'hDEAD_BEEF);
        check("rdinj_nrd", n_rd, 1);
        check("rdinj_nwr", n_wr, 0);
        check("rdinj_addr", {24'd0, log_addr[0]}, 32'h04);
        check_rsp_gone("rdinj");

        // RD_STAT: bit31 replaced by resetOut
        clear_log();
        bus.reset_out = 1'b1;
        stat_q = '{32'h0000_0013};
        send(OP_RD_STAT, 32'h0);
        wait_rsp("rdst_rsp", 20);
        check("rdst_data", rsp_data, 32'h8000_0013);
        check("rdst_addr", {24'd0, log_addr[0]}, 32'h00);
        check_rsp_gone("rdst");
        bus.reset_out = 1'b0;

        // CPU_RST: two writes, rsp_data 0
        clear_log();
        send(OP_CPU_RST, 32'h0);
        wait_rsp("crst_rsp", 20);
        check("crst_nwr", n_wr, 2);
        check("crst_nrd", n_rd, 0);
        check("crst_w0", log_data[0], 32'h0001_0000);
        check("crst_w1", log_data[1], 32'h0100_0000);
        check("crst_a1", {24'd0, log_addr[1]}, 32'h00);
        check("crst_data", rsp_data, 32'h0);
        check_rsp_gone("crst");

        // STEP needs halt=1 and busy=0; 0x6 keeps it polling
        clear_log();
        stat_q = '{32'h6, 32'h2};
        send(OP_STEP, 32'h0);
        wait_rsp("step_rsp", 100);
        check("step_wdata", log_data[0], 32'h0200_0010);
        check("step_nrd", n_rd, 2);
        check("step_data", rsp_data, 32'h2);
        check_rsp_gone("step");

        // Reserved op: error two cycles after accept, no bus traffic
        clear_log();
        send(OP_RSVD, 32'h0);
        check("rsvd_c1_valid", {31'd0, rsp_valid}, 32'd0);
        check("rsvd_c1_ready", {31'd0, req_ready}, 32'd0);
        tick();
        check("rsvd_c2_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsvd_err", {31'd0, rsp_err}, 32'd1);
        check("rsvd_fire", n_fire, 0);
        check_rsp_gone("rsvd");

        // Reset during the poll gap of STEP abandons the op
        clear_log();
        send(OP_STEP, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_cmd", {31'd0, bus.cmd_valid}, 32'd0);
        check("mid_rst_data", rsp_data, 32'd0);
        check("mid_rst_addr", {24'd0, bus.cmd_addr}, 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_ready_back", {31'd0, req_ready}, 32'd1);
        clear_log();
        send(OP_RESUME, 32'h0);
        wait_rsp("resume_rsp", 20);
        check("resume_wdata", log_data[0], 32'h0200_0000);
        check("resume_nwr", n_wr, 1);
        check("resume_nrd", n_rd, 0);
        check_rsp_gone("resume");

        // HALT with status stuck at 0
        clear_log();
        send(OP_HALT, 32'h0);
`ifdef DBG_CMD_TIMEOUT_EN
        wait_rsp("to_rsp", 300);
        check("to_nrd", n_rd, 8);
        check("to_err", {31'd0, rsp_err}, 32'd1);
        check("to_data", rsp_data, 32'd0);
        check_rsp_gone("to");
`else
        begin
            int k = 0;
            logic saw_rsp = 1'b0;
            while (n_rd < 100 && k < 1000) begin
                tick();
                if (rsp_valid === 1'b1) saw_rsp = 1'b1;
                k++;
            end
            check("nto_reached_100", {31'd0, (n_rd >= 100)}, 32'd1);
            check("nto_no_rsp", {31'd0, saw_rsp}, 32'd0);
            check("nto_busy", {31'd0, req_ready}, 32'd0);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            tick();
            check("nto_ready_after_rst", {31'd0, req_ready}, 32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
